screensaver_motion: RTL and testbench

- Per-frame logo motion controller for the VGA screensaver; sits directly upstream of the image/pixel generator and alongside the VGA timing generator.
- On each frame-start pulse from the timing generator it advances the logo's top-left (x,y) position and bounces it off the active-area edges.
- It also steps an RGB444 tint palette on every bounce, giving the classic "bouncing logo" screensaver.
- Outputs are held stable for the whole visible frame; they change only during the update sequence that follows frame_start.

---
 rtl/screensaver_motion.sv | 179 +++++++++++++++++
 tb/tb_screensaver_motion.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/screensaver_motion.sv
// rtl/screensaver_motion.sv - per-frame bouncing-logo position and tint controller
// Optional SCREENSAVER_SPEEDUP_EN: corner hits raise the step size, saturating at 8.
module screensaver_motion #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LOGO_W   = 128,
  parameter int LOGO_H   = 64,
  parameter int SPEED    = 2,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 50
) (
  input  logic        clk_25_175,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pause,
  output logic [9:0]  logo_x,
  output logic [9:0]  logo_y,
  output logic [11:0] tint,
  output logic        bounce,
  output logic        corner_hit,
  output logic        busy
);

  localparam logic [10:0] XMAX = 11'(H_ACTIVE - LOGO_W);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - LOGO_H);

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, COLOR} state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards 0
  logic        hx_q, hx_d, hy_q, hy_d;
  logic [2:0]  pal_q, pal_d;
  logic        bounce_q, bounce_d, corner_q, corner_d, busy_q, busy_d;
  logic [9:0]  step;

`ifdef SCREENSAVER_SPEEDUP_EN
  logic [3:0]  spd_q, spd_d;
  assign step = {6'd0, spd_q};
`else
  assign step = 10'(SPEED);
`endif

  always_ff @(posedge clk_25_175 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_INIT);
      dx_q     <= 1'b0;
      dy_q     <= 1'b0;
      hx_q     <= 1'b0;
      hy_q     <= 1'b0;
      pal_q    <= 3'd0;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SCREENSAVER_SPEEDUP_EN
      spd_q    <= 4'(SPEED);
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      pal_q    <= pal_d;
      bounce_q <= bounce_d;
      corner_q <= corner_d;
      busy_q   <= busy_d;
`ifdef SCREENSAVER_SPEEDUP_EN
      spd_q    <= spd_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    hx_d     = hx_q;
    hy_d     = hy_q;
    pal_d    = pal_q;
    bounce_d = 1'b0;
    corner_d = 1'b0;
    busy_d   = busy_q;
`ifdef SCREENSAVER_SPEEDUP_EN
    spd_d    = spd_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start && !pause) begin
          state_d = UPD_X;
          busy_d  = 1'b1;
        end
      end
      UPD_X: begin
        // Edge tests run at 11 bits so x+step cannot wrap.
        if (!dx_q) begin
          if (({1'b0, x_q} + {1'b0, step}) >= XMAX) begin
            x_d  = XMAX[9:0];
            dx_d = 1'b1;
            hx_d = 1'b1;
          end else begin
            x_d = x_q + step;
          end
        end else begin
          if (x_q <= step) begin
            x_d  = 10'd0;
            dx_d = 1'b0;
            hx_d = 1'b1;
          end else begin
            x_d = x_q - step;
          end
        end
        state_d = UPD_Y;
      end
      UPD_Y: begin
        if (!dy_q) begin
          if (({1'b0, y_q} + {1'b0, step}) >= YMAX) begin
            y_d  = YMAX[9:0];
            dy_d = 1'b1;
            hy_d = 1'b1;
          end else begin
            y_d = y_q + step;
          end
        end else begin
          if (y_q <= step) begin
            y_d  = 10'd0;
            dy_d = 1'b0;
            hy_d = 1'b1;
          end else begin
            y_d = y_q - step;
          end
        end
        state_d = COLOR;
      end
      default: begin
        if (hx_q || hy_q) begin
          pal_d    = pal_q + 3'd1;
          bounce_d = 1'b1;
        end
        if (hx_q && hy_q) begin
          corner_d = 1'b1;
`ifdef SCREENSAVER_SPEEDUP_EN
          if (spd_q < 4'd8) spd_d = spd_q + 4'd1;
`endif
        end
        hx_d    = 1'b0;
        hy_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    case (pal_q)
      3'd0:    tint = 12'hF00;
      3'd1:    tint = 12'hF80;
      3'd2:    tint = 12'hFF0;
      3'd3:    tint = 12'h0F0;
      3'd4:    tint = 12'h0FF;
      3'd5:    tint = 12'h00F;
      3'd6:    tint = 12'hF0F;
      default: tint = 12'hFFF;
    endcase
  end

  assign logo_x     = x_q;
  assign logo_y     = y_q;
  assign bounce     = bounce_q;
  assign corner_hit = corner_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_screensaver_motion.sv
// tb/tb_screensaver_motion.sv - directed bench for screensaver_motion
module tb_screensaver_motion;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs_a = 1'b0, pause_a = 1'b0, fs_b = 1'b0, pause_b = 1'b0;
  logic [9:0]  x_a, y_a, x_b, y_b;
  logic [11:0] tint_a, tint_b;
  logic bounce_a, corner_a, busy_a, bounce_b, corner_b, busy_b;

  int n_total = 0;
  int n_pass  = 0;
  int nb      = 0;
  int pulses  = 0;
  logic b_seen, c_seen;
  logic [11:0] pal [8];

  always #20 clk = ~clk;

  screensaver_motion u_a (
    .clk_25_175(clk), .rst(rst), .frame_start(fs_a), .pause(pause_a),
    .logo_x(x_a), .logo_y(y_a), .tint(tint_a),
    .bounce(bounce_a), .corner_hit(corner_a), .busy(busy_a)
  );

  screensaver_motion #(.X_INIT(510), .Y_INIT(414)) u_b (
    .clk_25_175(clk), .rst(rst), .frame_start(fs_b), .pause(pause_b),
    .logo_x(x_b), .logo_y(y_b), .tint(tint_b),
    .bounce(bounce_b), .corner_hit(corner_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full frame update on instance B; tracks bounce pulses against the palette.
  task automatic frame_b();
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    b_seen = 1'b0;
    c_seen = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick();
      if (bounce_b) pulses++;
      b_seen = b_seen | bounce_b;
      c_seen = c_seen | corner_b;
    end
    if (b_seen) begin
      nb++;
      check("palette_step", {20'd0, tint_b}, {20'd0, pal[nb % 8]});
    end
  endtask

  initial begin
    pal[0] = 12'hF00; pal[1] = 12'hF80; pal[2] = 12'hFF0; pal[3] = 12'h0F0;
    pal[4] = 12'h0FF; pal[5] = 12'h00F; pal[6] = 12'hF0F; pal[7] = 12'hFFF;

    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_x", 32'(x_a), 32'd100);
    check("rst_y", 32'(y_a), 32'd50);
    check("rst_tint", 32'(tint_a), 32'hF00);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_bounce", 32'(bounce_a), 32'd0);

    // Single frame: latency and busy width
    fs_a = 1'b1; tick(); fs_a = 1'b0;
    check("n1_busy", 32'(busy_a), 32'd1);
    check("n1_x_old", 32'(x_a), 32'd100);
    tick();
    check("n2_x", 32'(x_a), 32'd102);
    check("n2_y_old", 32'(y_a), 32'd50);
    check("n2_busy", 32'(busy_a), 32'd1);
    tick();
    check("n3_y", 32'(y_a), 32'd52);
    check("n3_busy", 32'(busy_a), 32'd1);
    tick();
    check("n4_busy", 32'(busy_a), 32'd0);
    check("n4_bounce", 32'(bounce_a), 32'd0);
    check("n4_tint", 32'(tint_a), 32'hF00);

    // Paused frame is skipped
    pause_a = 1'b1; fs_a = 1'b1; tick(); fs_a = 1'b0; pause_a = 1'b0;
    check("pause_busy", 32'(busy_a), 32'd0);
    tick(); tick(); tick();
    check("pause_x", 32'(x_a), 32'd102);
    check("pause_y", 32'(y_a), 32'd52);

    // Second frame_start while busy is dropped
    fs_a = 1'b1; tick(); tick(); fs_a = 1'b0;
    tick(); tick(); tick();
    check("dbl_x", 32'(x_a), 32'd104);
    check("dbl_y", 32'(y_a), 32'd54);
    check("dbl_busy", 32'(busy_a), 32'd0);

    // Asynchronous reset during UPD_Y
    fs_a = 1'b1; tick(); fs_a = 1'b0; tick();
    check("mid_x", 32'(x_a), 32'd106);
    #2 rst = 1'b1;
    #1;
    check("arst_x", 32'(x_a), 32'd100);
    check("arst_y", 32'(y_a), 32'd50);
    check("arst_tint", 32'(tint_a), 32'hF00);
    check("arst_busy", 32'(busy_a), 32'd0);
    tick(); rst = 1'b0; tick(); tick();
    check("arst_bounce", 32'(bounce_a), 32'd0);
    check("arst_idle", 32'(busy_a), 32'd0);

    // Corner hit on instance B
    frame_b();
    check("c_x", 32'(x_b), 32'd512);
    check("c_y", 32'(y_b), 32'd416);
    check("c_bounce", 32'(b_seen), 32'd1);
    check("c_corner", 32'(c_seen), 32'd1);
    check("c_pulses", 32'(pulses), 32'd1);
    check("c_tint", 32'(tint_b), 32'hF80);
    frame_b();
`ifdef SCREENSAVER_SPEEDUP_EN
    check("f2_x", 32'(x_b), 32'd509);
    check("f2_y", 32'(y_b), 32'd413);
`else
    check("f2_x", 32'(x_b), 32'd510);
    check("f2_y", 32'(y_b), 32'd414);
    check("f2_bounce", 32'(b_seen), 32'd0);
    for (int f = 3; f <= 256; f++) frame_b();
    check("f256_x", 32'(x_b), 32'd2);
    check("f256_y", 32'(y_b), 32'd94);
    frame_b();
    check("f257_x", 32'(x_b), 32'd0);
    check("f257_bounce", 32'(b_seen), 32'd1);
    check("f257_corner", 32'(c_seen), 32'd0);
    check("f257_tint", 32'(tint_b), 32'h0F0);
    frame_b();
    check("f258_x", 32'(x_b), 32'd2);
`endif

    // Keep bouncing until the palette wraps
    for (int f = 0; f < 3000 && nb < 8; f++) frame_b();
    check("wrap_count", 32'(nb), 32'd8);
    check("wrap_tint", 32'(tint_b), 32'hF00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
